// File: rtl/roulette_led_gen.sv
// Roulette LED spinner: an LFSR picks the start position, the step rate decelerates until stop.
// Optional macro ROULETTE_BLINK_EN blinks the result LED while idle after a spin.
module roulette_led_gen #(
  parameter int unsigned N_POS         = 8,
  parameter int unsigned BASE_INTERVAL = 50000,
  parameter int unsigned SLOW_STEP     = 25000,
  parameter int unsigned FAST_STEPS    = 4,
  parameter int unsigned MAX_INTERVAL  = 400000,
  parameter logic [15:0] SEED          = 16'hACE1,
  parameter int unsigned BLINK_HALF    = 12500000,
  localparam int unsigned PW           = (N_POS > 1) ? $clog2(N_POS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_spin,
  input  logic             stop_req,
  output logic [N_POS-1:0] led_out,
  output logic [PW-1:0]    result_pos,
  output logic             spin_done,
  output logic             spin_active
);

  localparam int unsigned Thresh = BASE_INTERVAL + SLOW_STEP * FAST_STEPS;
  localparam bit ParamsOk = (N_POS >= 2) && (N_POS <= 32) && (MAX_INTERVAL >= Thresh) &&
                            (SEED != 16'd0) && (BLINK_HALF >= 1);

  if (!ParamsOk) begin : g_param_check
    $error("roulette_led_gen: illegal parameter set");
  end

  typedef enum logic [1:0] {StIdle, StRun, StSlow, StStop} state_e;

  state_e         r_state, w_state_nxt;
  logic [15:0]    r_lfsr;
  logic           w_fb;
  logic [PW-1:0]  r_pos, w_pos_nxt, w_pos_inc, w_start_pos;
  logic [31:0]    r_cnt, w_cnt_nxt;
  logic [31:0]    r_interval, w_interval_nxt;
  logic [31:0]    w_start32;
  logic [32:0]    w_slow_sum;
  logic [31:0]    w_slow_iv;
  logic           w_step;
  logic [PW-1:0]  w_result_nxt;
  logic           w_done_nxt;
  logic [N_POS-1:0] w_onehot;
  logic           w_led_mask;

  assign w_fb        = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_start32   = {16'd0, r_lfsr} % N_POS;
  assign w_start_pos = w_start32[PW-1:0];
  assign w_pos_inc   = (r_pos == PW'(N_POS - 1)) ? '0 : r_pos + 1'b1;
  assign w_step      = (r_cnt >= r_interval);
  assign w_onehot    = N_POS'(1) << r_pos;

  // 33-bit sum so saturation is exact even near the top of the 32-bit range.
  assign w_slow_sum  = {1'b0, r_interval} + {1'b0, 32'(2 * SLOW_STEP)};
  assign w_slow_iv   = (w_slow_sum >= {1'b0, 32'(MAX_INTERVAL)}) ? 32'(MAX_INTERVAL)
                                                                 : w_slow_sum[31:0];

  always_comb begin
    w_state_nxt    = r_state;
    w_pos_nxt      = r_pos;
    w_cnt_nxt      = r_cnt;
    w_interval_nxt = r_interval;
    w_result_nxt   = result_pos;
    w_done_nxt     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start_spin) begin
          w_pos_nxt      = w_start_pos;
          w_interval_nxt = 32'(BASE_INTERVAL);
          w_cnt_nxt      = '0;
          w_state_nxt    = StRun;
        end
      end
      StRun: begin
        // Early stop freezes interval and counter for this cycle.
        if (stop_req) begin
          w_state_nxt = StSlow;
        end else begin
          if (r_interval >= Thresh) w_state_nxt = StSlow;
          if (w_step) begin
            w_pos_nxt = w_pos_inc;
            w_cnt_nxt = '0;
            if (r_interval < Thresh) w_interval_nxt = r_interval + SLOW_STEP;
          end else begin
            w_cnt_nxt = r_cnt + 32'd1;
          end
        end
      end
      StSlow: begin
        if (r_interval >= MAX_INTERVAL) begin
          w_state_nxt = StStop;
        end else if (w_step) begin
          w_pos_nxt      = w_pos_inc;
          w_cnt_nxt      = '0;
          w_interval_nxt = w_slow_iv;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      StStop: begin
        w_result_nxt = r_pos;
        w_done_nxt   = 1'b1;
        w_state_nxt  = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

`ifdef ROULETTE_BLINK_EN
  logic [31:0] r_blink_cnt;
  logic        r_blink_on;
  logic        r_blink_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b0;
      r_blink_en  <= 1'b0;
    end else if (r_state == StStop) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
      r_blink_en  <= 1'b1;
    end else if (r_state == StIdle && start_spin) begin
      r_blink_en  <= 1'b0;
    end else if (r_blink_en) begin
      if (r_blink_cnt >= BLINK_HALF - 1) begin
        r_blink_cnt <= '0;
        r_blink_on  <= ~r_blink_on;
      end else begin
        r_blink_cnt <= r_blink_cnt + 32'd1;
      end
    end
  end

  assign w_led_mask = ~r_blink_en | r_blink_on;
`else
  assign w_led_mask = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_lfsr      <= SEED;
      r_pos       <= '0;
      r_cnt       <= '0;
      r_interval  <= 32'(BASE_INTERVAL);
      led_out     <= '0;
      result_pos  <= '0;
      spin_done   <= 1'b0;
      spin_active <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lfsr      <= {r_lfsr[14:0], w_fb};
      r_pos       <= w_pos_nxt;
      r_cnt       <= w_cnt_nxt;
      r_interval  <= w_interval_nxt;
      led_out     <= w_onehot & {N_POS{w_led_mask}};
      result_pos  <= w_result_nxt;
      spin_done   <= w_done_nxt;
      spin_active <= (r_state == StRun) || (r_state == StSlow);
    end
  end

endmodule
